// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types and constants for the io_timer countdown timer:
//                FSM state encoding, register word offsets, CTRL bit indices,
//                mode codes and the byte-enable to lane-mask helper.
//  Revision    : 1.0  initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } timer_state_t;

    // Word offsets on dev_addr
    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PRESET = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;

    // CTRL layout: bit0 EN, bits[2:1] MODE, bit3 IM
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Expand each byte enable into eight identical mask bits.
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_prescaler
//  Description : Tick generator. Emits a one-cycle tick every PRESCALE clocks.
//                The phase counter restarts whenever clear is high so that the
//                first tick after a LOAD comes a full PRESCALE period later.
//  Revision    : 1.0  initial release
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset
//                clear - restart the prescale phase
//                tick  - count-enable pulse
// ============================================================================
module timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              c_cnt_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(PRESCALE - 1);

    logic [c_cnt_w-1:0] r_phase;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_phase <= '0;
        end else if (r_phase == c_last) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + c_cnt_w'(1);
        end
    end

    assign tick = (r_phase == c_last);

endmodule
`default_nettype wire

// File: rtl/io_timer.sv
`default_nettype none
// ============================================================================
//  Module      : io_timer
//  Description : Memory-mapped countdown timer on the device side of the IO
//                bridge. Registers: CTRL (0), PRESET (1), COUNT (2, read-only),
//                offset 3 reserved. Byte-lane merged writes, read data
//                registered one cycle after the strobe, level interrupt.
//                Optional macro TIMER_PRESCALE_EN: when defined, COUNT steps
//                only on a tick every PRESCALE clocks (timer_prescaler);
//                otherwise it steps every clock and PRESCALE is ignored.
//  Revision    : 1.0  initial release
//  Ports       : clk      - system clock
//                reset    - synchronous active-high reset
//                dev_sel  - bridge decode hit for this device
//                dev_we   - write strobe
//                dev_re   - read strobe
//                dev_addr - word offset
//                dev_wd   - write data (already lane-shifted)
//                dev_be   - byte enables
//                dev_rd   - registered read data
//                irq      - level interrupt (pending & IM)
// ============================================================================
module io_timer
    import timer_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dev_sel,
    input  logic        dev_we,
    input  logic        dev_re,
    input  logic [1:0]  dev_addr,
    input  logic [31:0] dev_wd,
    input  logic [3:0]  dev_be,
    output logic [31:0] dev_rd,
    output logic        irq
);

    timer_state_t       r_state;
    timer_state_t       w_next_state;
    logic [CTRL_W-1:0]  r_ctrl;
    logic [CNT_W-1:0]   r_preset;
    logic [CNT_W-1:0]   r_count;
    logic               r_pending;

    logic               w_tick;
    logic               w_load;
    logic               w_dec;
    logic               w_set_pend;
    logic               w_clr_en;
    logic               w_wr;
    logic               w_rd;
    logic               w_ctrl_wr;
    logic               w_preset_wr;
    logic [31:0]        w_mask;
    logic [31:0]        w_rdata;
    logic               w_en;
    logic [1:0]         w_mode;

    assign w_en   = r_ctrl[CTRL_EN];
    assign w_mode = r_ctrl[CTRL_MODE_LO +: 2];
    assign irq    = r_pending & r_ctrl[CTRL_IM];

    // ------------------------------------------------------------------
    // Tick source
    // ------------------------------------------------------------------
`ifdef TIMER_PRESCALE_EN
    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (w_load),
        .tick  (w_tick)
    );
`else
    // Always high for any legal PRESCALE (>= 1): one step per clock.
    assign w_tick = (PRESCALE >= 1);
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_wr        = dev_sel && dev_we;
    assign w_rd        = dev_sel && dev_re;
    assign w_ctrl_wr   = w_wr && (dev_addr == TMR_CTRL);
    assign w_preset_wr = w_wr && (dev_addr == TMR_PRESET);
    assign w_mask      = be_mask(dev_be);

    always_comb begin
        w_rdata = '0;
        case (dev_addr)
            TMR_CTRL:   w_rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
            TMR_PRESET: w_rdata = 32'(r_preset);
            TMR_COUNT:  w_rdata = 32'(r_count);
            default:    w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        w_set_pend   = 1'b0;
        w_clr_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_en) w_next_state = LOAD;
            end
            LOAD: begin
                w_load       = 1'b1;
                w_next_state = CNT;
            end
            CNT: begin
                // The zero test waits for a tick too, so the final count
                // value lasts a full tick period like every other value.
                if (!w_en) begin
                    w_next_state = IDLE;
                end else if (w_tick) begin
                    if (r_count == '0) begin
                        w_next_state = INT;
                        w_set_pend   = 1'b1;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            INT: begin
                case (w_mode)
                    MODE_RELOAD:  w_next_state = LOAD;
                    MODE_ONESHOT: begin
                        w_clr_en     = 1'b1;
                        w_next_state = IDLE;
                    end
                    default: begin
                        w_clr_en     = 1'b1;
                        w_next_state = IDLE;
                    end
                endcase
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= '0;
        end else if (w_ctrl_wr) begin
            // A CPU write beats the one-shot EN clear in the same cycle.
            r_ctrl <= (r_ctrl & ~w_mask[CTRL_W-1:0]) | (dev_wd[CTRL_W-1:0] & w_mask[CTRL_W-1:0]);
        end else if (w_clr_en) begin
            r_ctrl[CTRL_EN] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_preset <= '0;
        end else if (w_preset_wr) begin
            r_preset <= (r_preset & ~w_mask[CNT_W-1:0]) | (dev_wd[CNT_W-1:0] & w_mask[CNT_W-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= r_preset;
        end else if (w_dec) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Set has priority over a clearing write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (w_set_pend) begin
            r_pending <= 1'b1;
        end else if (w_ctrl_wr || w_preset_wr) begin
            r_pending <= 1'b0;
        end
    end

    // Read data samples the pre-write register values.
    always_ff @(posedge clk) begin
        if (reset) begin
            dev_rd <= '0;
        end else if (w_rd) begin
            dev_rd <= w_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_timer
//  Description : Self-checking bench for io_timer. Expected read data is
//                queued when a read is driven and popped when dev_rd updates.
//                Counting-timing tests assume the default (unprescaled) build;
//                the prescale test runs when TIMER_PRESCALE_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_io_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        dev_sel;
    logic        dev_we;
    logic        dev_re;
    logic [1:0]  dev_addr;
    logic [31:0] dev_wd;
    logic [3:0]  dev_be;
    logic [31:0] dev_rd;
    logic        irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    io_timer #(
        .CNT_W    (32),
        .PRESCALE (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .dev_sel  (dev_sel),
        .dev_we   (dev_we),
        .dev_re   (dev_re),
        .dev_addr (dev_addr),
        .dev_wd   (dev_wd),
        .dev_be   (dev_be),
        .dev_rd   (dev_rd),
        .irq      (irq)
    );

    // ---------------- bus drivers (stimulus only) ----------------
    task automatic bus_idle();
        dev_sel = 1'b0; dev_we = 1'b0; dev_re = 1'b0;
        dev_addr = 2'd0; dev_wd = 32'd0; dev_be = 4'd0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        dev_sel = 1'b1; dev_we = 1'b1; dev_re = 1'b0;
        dev_addr = a; dev_wd = d; dev_be = be;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] e);
        @(negedge clk);
        exp_q.push_back(e);
        dev_sel = 1'b1; dev_we = 1'b0; dev_re = 1'b1; dev_addr = a;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic bus_rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] e);
        @(negedge clk);
        exp_q.push_back(e);
        dev_sel = 1'b1; dev_we = 1'b1; dev_re = 1'b1;
        dev_addr = a; dev_wd = d; dev_be = 4'hF;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] e;
        do_reset();
        n_checks++;
        if (dev_rd !== 32'd0) begin n_fail++; $display("FAIL reset_rd: got %h, expected 0", dev_rd); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b, expected 0", irq); end
        for (int a = 0; a < 3; a++) begin
            bus_read(2'(a), 32'd0);
            e = exp_q.pop_front();
            n_checks++;
            if (dev_rd !== e) begin n_fail++; $display("FAIL reset_reg%0d: got %h, expected %h", a, dev_rd, e); end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] e;
        do_reset();
        bus_write(2'd1, 32'd3, 4'hF);
        bus_write(2'd0, 32'h9, 4'hF);          // edge 0
        for (int k = 0; k < 6; k++) begin      // read in cycle k, data after edge k+1
            bus_read(2'd2, 32'(5 - k));
            e = exp_q.pop_front();
            if (k >= 2) begin
                n_checks++;
                if (dev_rd !== e) begin n_fail++; $display("FAIL oneshot_count k=%0d: got %h, expected %h", k, dev_rd, e); end
            end
            n_checks++;
            if (irq !== (k + 1 >= 6)) begin n_fail++; $display("FAIL oneshot_irq edge=%0d: got %b, expected %b", k + 1, irq, (k + 1 >= 6)); end
        end
        idle_cycles(1);
        bus_read(2'd0, 32'h8);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL oneshot_ctrl: got %h, expected %h", dev_rd, e); end
        idle_cycles(3);
        bus_read(2'd2, 32'd0);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL oneshot_hold0: got %h, expected %h", dev_rd, e); end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL oneshot_irq_sticky: got %b, expected 1", irq); end
        bus_write(2'd1, 32'd7, 4'hF);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL oneshot_irq_clear: got %b, expected 0", irq); end
        idle_cycles(3);
        bus_read(2'd2, 32'd0);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL oneshot_no_restart: got %h, expected %h", dev_rd, e); end
    endtask

    function automatic logic [31:0] reload_count(input int k);
        int ph;
        ph = (k - 2) % 5;
        return (ph == 0) ? 32'd2 : (ph == 1) ? 32'd1 : 32'd0;
    endfunction

    task automatic test_reload();
        logic [31:0] e;
        do_reset();
        bus_write(2'd1, 32'd2, 4'hF);
        bus_write(2'd0, 32'hB, 4'hF);          // edge 0; INT at edges 5,10,15
        for (int k = 0; k < 10; k++) begin
            bus_read(2'd2, reload_count(k));
            e = exp_q.pop_front();
            if (k >= 2) begin
                n_checks++;
                if (dev_rd !== e) begin n_fail++; $display("FAIL reload_count k=%0d: got %h, expected %h", k, dev_rd, e); end
            end
            n_checks++;
            if (irq !== (k + 1 >= 5)) begin n_fail++; $display("FAIL reload_irq edge=%0d: got %b, expected %b", k + 1, irq, (k + 1 >= 5)); end
        end
        bus_write(2'd0, 32'hB, 4'hF);          // cycle 10, clears at edge 11
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reload_clear: got %b, expected 0", irq); end
        for (int k = 11; k < 14; k++) begin
            bus_read(2'd2, reload_count(k));
            e = exp_q.pop_front();
            n_checks++;
            if (dev_rd !== e) begin n_fail++; $display("FAIL reload_count k=%0d: got %h, expected %h", k, dev_rd, e); end
            n_checks++;
            if (irq !== 1'b0) begin n_fail++; $display("FAIL reload_irq edge=%0d: got %b, expected 0", k + 1, irq); end
        end
        bus_write(2'd0, 32'hB, 4'hF);          // cycle 14: clear collides with set at edge 15
        n_checks++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL reload_set_wins: got %b, expected 1", irq); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] e;
        do_reset();
        bus_write(2'd1, 32'h11223344, 4'hF);
        bus_write(2'd1, 32'hAA000000, 4'b1000);
        bus_read(2'd1, 32'hAA223344);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL be_preset: got %h, expected %h", dev_rd, e); end
        bus_write(2'd1, 32'h0000BB00, 4'b0010);
        bus_read(2'd1, 32'hAA22BB44);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL be_preset_b1: got %h, expected %h", dev_rd, e); end
        bus_write(2'd2, 32'hFFFFFFFF, 4'hF);
        bus_read(2'd2, 32'd0);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL be_count_ro: got %h, expected %h", dev_rd, e); end
        bus_write(2'd0, 32'hFFFFFFF4, 4'hF);   // MODE=10 only, upper bits dropped
        bus_read(2'd0, 32'h4);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL be_ctrl_bits: got %h, expected %h", dev_rd, e); end
        bus_write(2'd3, 32'h12345678, 4'hF);
        bus_read(2'd3, 32'd0);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL be_reserved: got %h, expected %h", dev_rd, e); end
    endtask

    task automatic test_collision();
        logic [31:0] e;
        do_reset();
        bus_write(2'd1, 32'h11223344, 4'hF);
        bus_rw(2'd1, 32'h5, 32'h11223344);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL rw_old_value: got %h, expected %h", dev_rd, e); end
        bus_read(2'd1, 32'h5);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL rw_new_value: got %h, expected %h", dev_rd, e); end
        // Unselected strobes must change nothing.
        @(negedge clk);
        dev_sel = 1'b0; dev_we = 1'b1; dev_re = 1'b1;
        dev_addr = 2'd1; dev_wd = 32'hDEADBEEF; dev_be = 4'hF;
        @(posedge clk); #1;
        bus_idle();
        n_checks++;
        if (dev_rd !== 32'h5) begin n_fail++; $display("FAIL nosel_rd_hold: got %h, expected 00000005", dev_rd); end
        bus_read(2'd1, 32'h5);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL nosel_preset: got %h, expected %h", dev_rd, e); end
        bus_read(2'd3, 32'd0);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL read_off3: got %h, expected %h", dev_rd, e); end
        idle_cycles(2);
        n_checks++;
        if (dev_rd !== 32'd0) begin n_fail++; $display("FAIL rd_hold_idle: got %h, expected 0", dev_rd); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] e;
        do_reset();
        bus_write(2'd1, 32'd5, 4'hF);
        bus_write(2'd0, 32'h9, 4'hF);
        idle_cycles(3);
        bus_read(2'd1, 32'd5);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL mid_pre_rd: got %h, expected %h", dev_rd, e); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (dev_rd !== 32'd0) begin n_fail++; $display("FAIL mid_rst_rd: got %h, expected 0", dev_rd); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_irq: got %b, expected 0", irq); end
        reset = 1'b0;
        for (int a = 0; a < 3; a++) begin
            bus_read(2'(a), 32'd0);
            e = exp_q.pop_front();
            n_checks++;
            if (dev_rd !== e) begin n_fail++; $display("FAIL mid_rst_reg%0d: got %h, expected %h", a, dev_rd, e); end
        end
        idle_cycles(10);
        bus_read(2'd2, 32'd0);
        e = exp_q.pop_front();
        n_checks++;
        if (dev_rd !== e) begin n_fail++; $display("FAIL mid_rst_idle: got %h, expected %h", dev_rd, e); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_irq_late: got %b, expected 0", irq); end
    endtask

    task automatic test_prescale();
        logic [31:0] e;
        logic [31:0] x;
        do_reset();
        bus_write(2'd1, 32'd2, 4'hF);
        bus_write(2'd0, 32'h9, 4'hF);          // edge 0, CNT at edge 2, INT at edge 14
        for (int k = 0; k < 14; k++) begin
            x = (k < 6) ? 32'd2 : (k < 10) ? 32'd1 : 32'd0;
            bus_read(2'd2, x);
            e = exp_q.pop_front();
            if (k >= 2) begin
                n_checks++;
                if (dev_rd !== e) begin n_fail++; $display("FAIL pre_count k=%0d: got %h, expected %h", k, dev_rd, e); end
            end
            n_checks++;
            if (irq !== (k + 1 >= 14)) begin n_fail++; $display("FAIL pre_irq edge=%0d: got %b, expected %b", k + 1, irq, (k + 1 >= 14)); end
        end
    endtask

    initial begin
        bus_idle();
        reset = 1'b1;
        test_reset();
        test_byte_enable();
        test_collision();
        test_reset_midcount();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`else
        test_oneshot();
        test_reload();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
